// File: rtl/nb_info_line_ctrl.sv
// Requester-side controller for the neighbour-info line RAM: picture-start clear
// sweep, CU-width burst fill, and registered single-entry neighbour reads.
module nb_info_line_ctrl #(
    parameter int unsigned            addr_bits = 8,
    parameter int unsigned            data_bits = 16,
    parameter int unsigned            len_bits  = 4,
    parameter logic [data_bits-1:0]   clear_val = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pic_start,
    output logic                 busy,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [addr_bits-1:0] wr_addr,
    input  logic [len_bits-1:0]  wr_len,
    input  logic [data_bits-1:0] wr_data,
    input  logic                 rd_valid,
    output logic                 rd_ready,
    input  logic [addr_bits-1:0] rd_addr,
    output logic [data_bits-1:0] rd_data,
    output logic                 rd_data_valid,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [addr_bits-1:0] ram_addr,
    output logic [data_bits-1:0] ram_din,
    input  logic [data_bits-1:0] ram_dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        FILL  = 2'd2
    } state_t;

    localparam logic [addr_bits-1:0] last_addr = '1;
    localparam logic [addr_bits-1:0] addr_one  = addr_bits'(1);
    localparam logic [len_bits-1:0]  len_one   = len_bits'(1);

    state_t               state, state_nxt;
    logic [addr_bits-1:0] clr_cnt, clr_cnt_nxt;
    logic [addr_bits-1:0] base, base_nxt;
    logic [len_bits-1:0]  remaining, remaining_nxt;
    logic [data_bits-1:0] fill_data, fill_data_nxt;
    logic                 busy_nxt;
    logic                 rd_accept;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            clr_cnt       <= '0;
            base          <= '0;
            remaining     <= '0;
            fill_data     <= '0;
            busy          <= 1'b0;
            rd_data       <= '0;
            rd_data_valid <= 1'b0;
        end else begin
            state         <= state_nxt;
            clr_cnt       <= clr_cnt_nxt;
            base          <= base_nxt;
            remaining     <= remaining_nxt;
            fill_data     <= fill_data_nxt;
            busy          <= busy_nxt;
            rd_data_valid <= rd_accept;
            if (rd_accept) begin
                rd_data <= ram_dout;
            end
        end
    end

    // Next-state, RAM port drive and handshakes; one RAM access per cycle at most
    always_comb begin
        state_nxt     = state;
        clr_cnt_nxt   = clr_cnt;
        base_nxt      = base;
        remaining_nxt = remaining;
        fill_data_nxt = fill_data;
        busy_nxt      = busy;
        ram_en        = 1'b0;
        ram_we        = 1'b0;
        ram_addr      = '0;
        ram_din       = '0;
        rd_accept     = 1'b0;
        wr_ready      = (state == IDLE) && !pic_start;
        rd_ready      = (state == IDLE) && !pic_start && !wr_valid;

        case (state)
            IDLE: begin
                if (pic_start) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                    busy_nxt    = 1'b1;
                end else if (wr_valid) begin
                    ram_en        = 1'b1;
                    ram_we        = 1'b1;
                    ram_addr      = wr_addr;
                    ram_din       = wr_data;
                    base_nxt      = wr_addr + addr_one;
                    remaining_nxt = wr_len;
                    fill_data_nxt = wr_data;
                    if (wr_len != '0) begin
                        state_nxt = FILL;
                    end
                end else if (rd_valid) begin
                    ram_en    = 1'b1;
                    ram_addr  = rd_addr;
                    rd_accept = 1'b1;
                end
            end
            FILL: begin
                if (pic_start) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                    busy_nxt    = 1'b1;
                end else begin
                    ram_en        = 1'b1;
                    ram_we        = 1'b1;
                    ram_addr      = base;
                    ram_din       = fill_data;
                    base_nxt      = base + addr_one;
                    remaining_nxt = remaining - len_one;
                    if (remaining == len_one) begin
                        state_nxt = IDLE;
                    end
                end
            end
            CLEAR: begin
                if (pic_start) begin
                    clr_cnt_nxt = '0;
                end else begin
                    ram_en      = 1'b1;
                    ram_we      = 1'b1;
                    ram_addr    = clr_cnt;
                    ram_din     = clear_val;
                    clr_cnt_nxt = clr_cnt + addr_one;
                    if (clr_cnt == last_addr) begin
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // A reset cycle must not disturb RAM contents, even mid-sweep
        if (rst) begin
            ram_en = 1'b0;
            ram_we = 1'b0;
        end
    end

endmodule

// File: tb/tb_nb_info_line_ctrl.sv
// Bench for nb_info_line_ctrl: behavioural RAM plus an expected-contents array
// updated from burst/clear rules, exercised with directed and random traffic.
module tb_nb_info_line_ctrl;

    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 16;
    localparam int unsigned LW    = 4;
    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [DW-1:0] CLR = 16'h0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          pic_start;
    logic          busy;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [LW-1:0] wr_len;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_data_valid;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];

    int n_assert = 0;
    int n_fail   = 0;
    int we_no_en = 0;
    int rv_wrong = 0;
    logic rd_acc_q = 1'b0;

    always #5 clk = ~clk;

    nb_info_line_ctrl #(
        .addr_bits (AW),
        .data_bits (DW),
        .len_bits  (LW),
        .clear_val (CLR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pic_start     (pic_start),
        .busy          (busy),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_len        (wr_len),
        .wr_data       (wr_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
        .ram_en        (ram_en),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_din       (ram_din),
        .ram_dout      (ram_dout)
    );

    // Single-port RAM with asynchronous read
    assign ram_dout = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_en && ram_we) mem[ram_addr] = ram_din;
        if (ram_we && !ram_en) we_no_en++;
        rd_acc_q <= rd_valid && rd_ready && !rst;
    end

    // rd_data_valid must pulse exactly for the cycle after an accepted read
    always @(negedge clk) begin
        if (rd_data_valid !== rd_acc_q) rv_wrong++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Burst write; checks occupancy and updates the expected contents
    task automatic burst(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic [DW-1:0] d);
        int cyc;
        wr_valid = 1'b1; wr_addr = a; wr_len = l; wr_data = d;
        #1 chk("wr_ready_accept", 32'(wr_ready), 32'd1);
        tick();
        wr_valid = 1'b0;
        cyc = 1;
        while (!wr_ready && cyc < 64) begin
            cyc++;
            tick();
        end
        chk("burst_cycles", 32'(cyc), 32'(int'(l) + 1));
        for (int i = 0; i <= int'(l); i++) ref_mem[AW'(int'(a) + i)] = d;
    endtask

    // Back-to-back reads of n consecutive entries (wrapping)
    task automatic read_range(input logic [AW-1:0] start, input int n);
        logic [AW-1:0] a;
        for (int i = 0; i < n; i++) begin
            a = AW'(int'(start) + i);
            rd_valid = 1'b1; rd_addr = a;
            #1 if (i == 0) chk("rd_ready_idle", 32'(rd_ready), 32'd1);
            tick();
            chk("rd_valid_pulse", 32'(rd_data_valid), 32'd1);
            chk("rd_data", 32'(rd_data), 32'(ref_mem[a]));
        end
        rd_valid = 1'b0;
    endtask

    // Waits out a sweep, counting busy cycles and any cycle with a ready high
    task automatic wait_sweep(output int cnt, output int rdy_bad);
        cnt = 0; rdy_bad = 0;
        while (busy && cnt < 1000) begin
            if (wr_ready || rd_ready) rdy_bad++;
            cnt++;
            tick();
        end
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = CLR;
    endtask

    initial begin
        int cnt, bad, n;
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] = DW'($urandom);
            ref_mem[i] = mem[i];
        end
        rst = 1'b1; pic_start = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_len = '0;
        wr_data = '0; rd_valid = 1'b0; rd_addr = '0;
        tick(); tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_rd_valid", 32'(rd_data_valid), 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        rst = 1'b0;
        #1 chk("idle_wr_ready", 32'(wr_ready), 32'd1);
        chk("idle_rd_ready", 32'(rd_ready), 32'd1);
        chk("idle_ram_en", 32'(ram_en), 32'd0);

        // Picture-start clear sweep
        pic_start = 1'b1;
        tick();
        pic_start = 1'b0;
        wait_sweep(cnt, bad);
        chk("sweep_busy_cycles", 32'(cnt), 32'd256);
        chk("sweep_ready_low", 32'(bad), 32'd0);
        read_range(8'h00, 256);

        // Directed burst and boundary reads
        burst(8'h10, 4'd3, 16'hABCD);
        read_range(8'h0F, 6);
        chk("burst_edge_lo", 32'(ref_mem[8'h0F]), 32'h0);
        chk("burst_edge_in", 32'(ref_mem[8'h13]), 32'hABCD);

        // Wrap across the top entry
        burst(8'hFE, 4'd2, 16'h1234);
        read_range(8'hFE, 4);

        // Simultaneous write and read: write wins, read follows the burst
        wr_valid = 1'b1; wr_addr = 8'h40; wr_len = 4'd2; wr_data = 16'h5555;
        rd_valid = 1'b1; rd_addr = 8'h41;
        #1 chk("both_wr_ready", 32'(wr_ready), 32'd1);
        chk("both_rd_ready", 32'(rd_ready), 32'd0);
        tick();
        wr_valid = 1'b0;
        for (int i = 0; i < 3; i++) ref_mem[8'h40 + i] = 16'h5555;
        n = 0;
        while (!rd_ready && n < 16) begin
            n++;
            tick();
        end
        chk("rd_wait_cycles", 32'(n), 32'd2);
        chk("rd_no_early_valid", 32'(rd_data_valid), 32'd0);
        tick();
        rd_valid = 1'b0;
        chk("deferred_rd_valid", 32'(rd_data_valid), 32'd1);
        chk("deferred_rd_data", 32'(rd_data), 32'h5555);
        tick(); tick();
        chk("rd_valid_drop", 32'(rd_data_valid), 32'd0);
        chk("rd_data_hold", 32'(rd_data), 32'h5555);

        // Random traffic against the expected-contents model
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 1) == 1)
                burst(AW'($urandom), LW'($urandom), DW'($urandom));
            else
                read_range(AW'($urandom), int'($urandom_range(1, 4)));
        end
        read_range(8'h00, 256);

        // pic_start in the 2nd cycle of a long burst
        wr_valid = 1'b1; wr_addr = 8'h80; wr_len = 4'd7; wr_data = 16'hBEEF;
        tick();
        wr_valid = 1'b0; pic_start = 1'b1;
        #1 chk("abort_wr_ready", 32'(wr_ready), 32'd0);
        tick();
        pic_start = 1'b0;
        chk("abort_busy", 32'(busy), 32'd1);
        wait_sweep(cnt, bad);
        chk("abort_sweep_cycles", 32'(cnt), 32'd256);
        read_range(8'h00, 256);

        // Reset mid-sweep at clr_cnt=100
        for (int a = 0; a < int'(DEPTH); a += 16) burst(AW'(a), 4'hF, DW'($urandom) | 16'h1);
        pic_start = 1'b1;
        tick();
        pic_start = 1'b0;
        repeat (100) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rd_valid", 32'(rd_data_valid), 32'd0);
        #1 chk("midrst_idle", 32'(wr_ready), 32'd1);
        for (int i = 0; i < 100; i++) ref_mem[i] = CLR;
        read_range(8'h00, 256);

        tick();
        chk("we_implies_en", 32'(we_no_en), 32'd0);
        chk("rd_valid_protocol", 32'(rv_wrong), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/nb_info_line_ctrl.md
Name: nb_info_line_ctrl

Overview:
- Requester-side controller for the single-port distributed neighbour-info RAM, which holds per-4x4-column intra pred mode, ref_idx and mvp info for the row above.
- Drives the RAM's en/we/addr/data_in and consumes its asynchronous data_out.
- Provides three services, one RAM access per cycle:
  - picture-start clear sweep;
  - burst fill of consecutive entries with one value (CU-width writeback);
  - registered single-entry neighbour reads.
- Sits between CU decode/MV derivation and the RAM instance.

Parameters:
- addr_bits, 8, RAM address width; the RAM depth is 1<<addr_bits.
- data_bits, 16, RAM word width.
- len_bits, 4, burst length field width; a burst covers 1..(1<<len_bits) entries.
- clear_val, 0, word written during the clear sweep.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- pic_start  in  1  one-cycle pulse; starts the clear sweep.
- busy  out  1  high while a clear sweep is in progress.
- wr_valid  in  1  burst write request.
- wr_ready  out  1  the burst write request is accepted this cycle.
- wr_addr  in  addr_bits  first entry of the burst.
- wr_len  in  len_bits  number of entries minus 1.
- wr_data  in  data_bits  value written to every entry of the burst.
- rd_valid  in  1  read request.
- rd_ready  out  1  the read is accepted this cycle.
- rd_addr  in  addr_bits  read address.
- rd_data  out  data_bits  registered read data.
- rd_data_valid  out  1  one-cycle pulse qualifying rd_data.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  addr_bits  RAM address.
- ram_din  out  data_bits  RAM write data.
- ram_dout  in  data_bits  RAM asynchronous read data.

Behaviour:
- Reset (rst sampled high at posedge):
  - state IDLE; counters 0.
  - busy=0, rd_data=0, rd_data_valid=0.
  - RAM outputs are driven inactive while in IDLE with no request.
  - Reset overrides everything, including mid-sweep and mid-burst; any partial operation is abandoned.
- States: IDLE, CLEAR, FILL.
- Ready signals (combinational):
  - wr_ready = (state==IDLE) & !pic_start.
  - rd_ready = (state==IDLE) & !pic_start & !wr_valid.
- Priority within a cycle: pic_start > write > read.
- IDLE:
  - If pic_start: go to CLEAR, clr_cnt<=0, busy<=1. No RAM access this cycle.
  - Else if wr_valid:
    - Write entry wr_addr (ram_en=1, ram_we=1, ram_din=wr_data).
    - Latch base=wr_addr+1, remaining=wr_len, data=wr_data.
    - If wr_len!=0, go to FILL; else stay in IDLE.
  - Else if rd_valid:
    - ram_en=1, ram_we=0, ram_addr=rd_addr.
    - Next cycle: rd_data<=ram_dout and rd_data_valid=1.
    - Read latency is 1 cycle; back-to-back reads give one result per cycle.
- FILL:
  - Each cycle, write the latched data at base, then base<=base+1 and remaining<=remaining-1.
  - Return to IDLE after the cycle in which remaining==1 is written.
  - Total burst duration is wr_len+1 cycles, counting the accept cycle.
  - Addresses wrap modulo 1<<addr_bits; a burst crossing the top entry continues at 0.
  - pic_start during FILL aborts the burst (remaining entries are not written) and enters CLEAR next cycle.
- CLEAR:
  - Each cycle, write clear_val at clr_cnt, then clr_cnt++.
  - After writing entry (1<<addr_bits)-1, busy<=0 and return to IDLE.
  - The sweep takes exactly 1<<addr_bits write cycles.
  - pic_start during CLEAR restarts the sweep with clr_cnt<=0.
- rd_data holds its last value when rd_data_valid=0.
- rd_data_valid is never asserted for a cycle that was not an accepted read.
- ram_we=1 implies ram_en=1.
- At most one RAM access per cycle, so the single address port is never contended.

Test Plan:
- Reset then pic_start pulse, addr_bits=8: busy high for exactly 256 cycles; every entry reads back 0; wr_ready and rd_ready low throughout the sweep.
- Write wr_addr=0x10, wr_len=3, wr_data=0xABCD, then read 0x0F..0x14: expect 0, ABCD, ABCD, ABCD, ABCD, 0. The write occupies 4 cycles.
- Wrap-around: write wr_addr=0xFE, wr_len=2, wr_data=0x1234. Entries 0xFE, 0xFF and 0x00 all equal 0x1234; entry 0x01 is unchanged.
- wr_valid and rd_valid asserted together in IDLE: the write is accepted and rd_ready=0. The read is accepted on the first IDLE cycle after the burst, with rd_data_valid one cycle later.
- pic_start in the 2nd cycle of a wr_len=7 burst: the burst stops, busy asserts the next cycle, and the full sweep leaves all 256 entries equal to clear_val.
- rst asserted mid-CLEAR at clr_cnt=100: next cycle busy=0, state IDLE, rd_data_valid=0; entries 100..255 keep their prior contents.
